mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4:1 select mux among four requesters.

---
 rtl/mux4_arb_pkg.sv | 18 +
 rtl/mux4_rr_arbiter_pick.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared constants, state encoding and pointer helper for the 4-way
// round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Round-robin pointer advance; the 2-bit add wraps 3 back to 0.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
    return ptr + 2'd1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping
// modulo 4, and returns the first requester found.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [SEL_W-1:0] cand_s;

  // Priority scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    gnt_idx = 2'd0;
    any     = 1'b0;
    cand_s  = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = ptr + SEL_W'(k);
      if (!any && req[cand_s]) begin
        any     = 1'b1;
        gnt_idx = cand_s;
      end else begin
        any     = any;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving one shared 4:1 beat mux. A grant is held for a
// whole packet (or MAX_HOLD beats), then the next requester gets its turn.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       sel,
  output logic                   busy
);

  localparam int CNT_W = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};

  arb_state_e       state_r, state_nx_s;
  logic [SEL_W-1:0] sel_r, sel_nx_s;
  logic [SEL_W-1:0] ptr_r, ptr_nx_s;
  logic [CNT_W-1:0] beat_cnt_r, beat_cnt_nx_s;

  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             grant_s;
  logic             xfer_s;
  logic             hold_hit_s;
  logic             release_s;

  rr_pick4 u_pick (
    .req     (req_valid),
    .ptr     (ptr_r),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  // Grant qualification and release conditions for the current beat.
  always_comb begin
    grant_s    = (state_r == ST_GRANT) && !rst;
    xfer_s     = grant_s && req_valid[sel_r] && out_ready;
    hold_hit_s = (MAX_HOLD != 0) && (beat_cnt_r == HOLD_LAST);
    release_s  = xfer_s && (req_last[sel_r] || hold_hit_s);
  end

  // Next-state logic: lock onto the picked requester, count beats, release and rotate.
  always_comb begin
    state_nx_s    = state_r;
    sel_nx_s      = sel_r;
    ptr_nx_s      = ptr_r;
    beat_cnt_nx_s = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_nx_s    = ST_GRANT;
          sel_nx_s      = pick_idx_s;
          beat_cnt_nx_s = {CNT_W{1'b0}};
        end else begin
          state_nx_s    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_nx_s    = ST_IDLE;
          ptr_nx_s      = rr_next(sel_r);
          beat_cnt_nx_s = {CNT_W{1'b0}};
        end else if (xfer_s) begin
          beat_cnt_nx_s = beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          beat_cnt_nx_s = beat_cnt_r;
        end
      end
      default: begin
        state_nx_s    = ST_IDLE;
        beat_cnt_nx_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, select, pointer and beat counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sel_r      <= 2'd0;
      ptr_r      <= 2'd0;
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      sel_r      <= sel_nx_s;
      ptr_r      <= ptr_nx_s;
      beat_cnt_r <= beat_cnt_nx_s;
    end
  end

  // Beat mux and ready steering; only the granted requester ever sees ready.
  always_comb begin
    out_valid = 1'b0;
    out_data  = {DATA_W{1'b0}};
    out_last  = 1'b0;
    req_ready = 4'b0000;
    if (grant_s) begin
      out_valid        = req_valid[sel_r];
      out_data         = req_data[int'(sel_r)*DATA_W +: DATA_W];
      out_last         = req_last[sel_r];
      req_ready[sel_r] = out_ready;
    end else begin
      out_valid = 1'b0;
    end
  end

  assign sel  = sel_r;
  assign busy = grant_s;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a packet-level model.
module tb_mux4_rr_arbiter;

  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid, req_last, req_ready;
  logic [4*DW-1:0] req_data;
  logic          out_valid, out_last, out_ready, busy;
  logic [DW-1:0] out_data;
  logic [1:0]    sel;

  int checks = 0;
  int failures = 0;

  // Source side: remaining beats of the current packet and a beat sequence number.
  int rem[4];
  int seq[4];
  bit en[4];
  bit refill_one = 1'b0;
  bit rand_mode  = 1'b0;

  // Reference model: who owns the mux (-1 = nobody), rotation pointer, beats this grant.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_cnt   = 0;
  int   m_sel   = 0;
  bit   m_known = 1'b0;
  logic [3:0] e_ready;

  int glog[$];
  int gaps[$];
  int idle_run = 0;
  bit prev_busy = 1'b0;
  int seq0_start;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (rem[i] > 0) && en[i];
      req_last[i]  = (rem[i] == 1);
      req_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
    end
  endtask

  task automatic check_outs();
    logic ev, el;
    logic [7:0] ed;
    e_ready = 4'b0000;
    ev = 1'b0; el = 1'b0; ed = 8'h00;
    if (!m_known) return;
    if (!rst && m_owner >= 0) begin
      ev = req_valid[m_owner];
      ed = req_data[m_owner*DW +: DW];
      el = req_last[m_owner];
      e_ready[m_owner] = out_ready;
    end
    chk("sel", sel, m_sel);
    chk("busy", busy, (!rst && m_owner >= 0));
    chk("req_ready", req_ready, e_ready);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_data", out_data, ed);
      chk("out_last", out_last, el);
    end
    if (!rst) begin
      if (busy && !prev_busy) begin
        glog.push_back(int'(sel));
        gaps.push_back(idle_run);
        idle_run = 0;
      end else if (!busy) begin
        idle_run++;
      end
      prev_busy = busy;
    end
  endtask

  task automatic model_edge();
    bit found;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0; m_known = 1'b1;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req_valid[(m_ptr + k) % 4]) begin
          found = 1'b1;
          m_owner = (m_ptr + k) % 4;
          m_sel = m_owner;
          m_cnt = 0;
        end
      end
    end else if (req_valid[m_owner] && out_ready) begin
      m_cnt++;
      if (req_last[m_owner] || (MH != 0 && m_cnt == MH)) begin
        m_ptr = (m_sel + 1) % 4;
        m_owner = -1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic src_update();
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && e_ready[i]) begin
        seq[i]++;
        rem[i]--;
      end
      if (refill_one && rem[i] == 0) rem[i] = 1;
      if (rand_mode) begin
        if (rem[i] == 0 && ($urandom % 4) == 0) rem[i] = 1 + int'($urandom % 6);
        en[i] = ($urandom % 4) != 0;
      end
    end
  endtask

  task automatic step();
    drive();
    #1;
    check_outs();
    @(posedge clk);
    model_edge();
    src_update();
    @(negedge clk);
  endtask

  task automatic clear_log();
    glog.delete();
    gaps.delete();
    idle_run = 0;
    prev_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 1; seq[i] = 4 * i; en[i] = 1'b1;
    end
    @(negedge clk);

    // 1: reset held two cycles while every requester is valid
    step();
    step();
    drive();
    #1;
    chk("t1_sel", sel, 2'd0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_ready", req_ready, 4'b0000);
    chk("t1_valid", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) rem[i] = 0;
    rst = 1'b0;

    // 2: single 3-beat packet from requester 2, then ptr=3 favours 3 over 0
    out_ready = 1'b1;
    rem[2] = 3;
    clear_log();
    repeat (6) step();
    chk("t2_ngrants", glog.size(), 1);
    chk("t2_gnt", (glog.size() > 0) ? glog[0] : -1, 2);
    chk("t2_sel_hold", sel, 2'd2);
    chk("t2_busy", busy, 1'b0);
    rem[0] = 1; rem[3] = 1;
    clear_log();
    repeat (6) step();
    chk("t2_ptr_first", (glog.size() > 0) ? glog[0] : -1, 3);
    chk("t2_ptr_second", (glog.size() > 1) ? glog[1] : -1, 0);

    // 3: fairness with back-to-back single-beat packets
    do_reset();
    for (int i = 0; i < 4; i++) rem[i] = 1;
    refill_one = 1'b1;
    clear_log();
    repeat (11) step();
    refill_one = 1'b0;
    chk("t3_ngrants", glog.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_order", (glog.size() > k) ? glog[k] : -1, exp_order[k]);
      chk("t3_bubble", (gaps.size() > k) ? gaps[k] : -1, 1);
    end

    // 4: backpressure on requester 1; hold limit counts handshakes only
    do_reset();
    rem[1] = 5;
    clear_log();
    for (int s = 0; s < 12; s++) begin
      out_ready = ((s % 2) == 1);
      step();
    end
    chk("t4_ngrants", glog.size(), 2);
    chk("t4_gnt", (glog.size() > 1) ? glog[1] : -1, 1);
    chk("t4_drained", rem[1], 0);

    // 5: hold limit splits an 8-beat packet around a waiting requester 3
    do_reset();
    out_ready = 1'b1;
    rem[0] = 8; rem[3] = 2;
    seq0_start = seq[0];
    clear_log();
    repeat (9) step();
    drive();
    #1;
    chk("t5_resume", out_data, {2'd0, 6'(seq0_start + 4)});
    repeat (6) step();
    chk("t5_ngrants", glog.size(), 3);
    chk("t5_g0", (glog.size() > 0) ? glog[0] : -1, 0);
    chk("t5_g1", (glog.size() > 1) ? glog[1] : -1, 3);
    chk("t5_g2", (glog.size() > 2) ? glog[2] : -1, 0);

    // 6: reset lands on beat 2 of a 5-beat packet from requester 3
    do_reset();
    rem[3] = 5;
    clear_log();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive();
    #1;
    chk("t6_sel", sel, 2'd0);
    chk("t6_busy", busy, 1'b0);
    repeat (8) step();
    chk("t6_ngrants", glog.size(), 2);
    chk("t6_regrant", (glog.size() > 1) ? glog[1] : -1, 3);
    chk("t6_drained", rem[3], 0);

    // Randomized traffic, backpressure and occasional reset
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rst = (($urandom % 97) == 0);
      out_ready = (($urandom % 4) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
